// File: rtl/systolic_feeder.sv
// Skews activation rows onto the systolic array's left edge: lane i lags lane 0 by i cycles.
// Optional SYSTOLIC_FEEDER_PERF_EN adds saturating perf_rows / perf_bubbles counters.
module systolic_feeder #(
  parameter int unsigned N      = 2,
  parameter int unsigned DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N*DATA_W-1:0]   in_row,
  input  logic                  in_last,
  output logic [N*DATA_W-1:0]   sys_data_out,
  output logic [N-1:0]          lane_valid,
  output logic                  sys_start,
  output logic                  busy,
  output logic                  done
`ifdef SYSTOLIC_FEEDER_PERF_EN
  ,
  output logic [15:0]           perf_rows,
  output logic [15:0]           perf_bubbles
`endif
);

  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_drain_cnt;
  logic [CNT_W-1:0]   w_drain_cnt_nxt;
  logic               w_accept;

  logic [N*DATA_W-1:0] r_in_data;
  logic                r_in_valid;
  logic                r_in_last;

  assign in_ready = !rst && (r_state != S_DRAIN);
  assign w_accept = in_valid & in_ready;
  assign busy     = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
    end
  end

  // DRAIN lasts exactly N cycles, long enough for the last row to exit lane N-1.
  always_comb begin
    w_state_nxt     = r_state;
    w_drain_cnt_nxt = r_drain_cnt;
    case (r_state)
      S_IDLE, S_STREAM: begin
        if (w_accept) begin
          if (in_last) begin
            w_state_nxt     = S_DRAIN;
            w_drain_cnt_nxt = '0;
          end else begin
            w_state_nxt = S_STREAM;
          end
        end
      end
      S_DRAIN: begin
        if (r_drain_cnt == CNT_W'(N - 1)) begin
          w_state_nxt     = S_IDLE;
          w_drain_cnt_nxt = '0;
        end else begin
          w_drain_cnt_nxt = r_drain_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_drain_cnt_nxt = '0;
      end
    endcase
  end

  // Common input register; non-accept cycles load a zero bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_data  <= '0;
      r_in_valid <= 1'b0;
      r_in_last  <= 1'b0;
    end else begin
      r_in_data  <= w_accept ? in_row : '0;
      r_in_valid <= w_accept;
      r_in_last  <= w_accept & in_last;
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    if (gi == 0) begin : g_head
      assign sys_data_out[0 +: DATA_W] = r_in_data[0 +: DATA_W];
      assign lane_valid[0]             = r_in_valid;
    end else begin : g_dly
      logic [DATA_W-1:0] r_dly_data [gi];
      logic [gi-1:0]     r_dly_valid;

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < gi; k++) begin
            r_dly_data[k] <= '0;
          end
          r_dly_valid <= '0;
        end else begin
          r_dly_data[0]  <= r_in_data[gi*DATA_W +: DATA_W];
          r_dly_valid[0] <= r_in_valid;
          for (int k = 1; k < gi; k++) begin
            r_dly_data[k]  <= r_dly_data[k-1];
            r_dly_valid[k] <= r_dly_valid[k-1];
          end
        end
      end

      assign sys_data_out[gi*DATA_W +: DATA_W] = r_dly_data[gi-1];
      assign lane_valid[gi]                    = r_dly_valid[gi-1];
    end
  end

  assign sys_start = r_in_valid;

  // End-of-matrix flag rides alongside lane N-1 so done meets its last element.
  if (N > 1) begin : g_done_dly
    logic [N-2:0] r_last_dly;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_last_dly <= '0;
      end else begin
        r_last_dly[0] <= r_in_last;
        for (int k = 1; k < int'(N) - 1; k++) begin
          r_last_dly[k] <= r_last_dly[k-1];
        end
      end
    end

    assign done = r_last_dly[N-2];
  end else begin : g_done_head
    assign done = r_in_last;
  end

`ifdef SYSTOLIC_FEEDER_PERF_EN
  logic [15:0] r_perf_rows;
  logic [15:0] r_perf_bubbles;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_rows    <= '0;
      r_perf_bubbles <= '0;
    end else begin
      if (w_accept && (r_perf_rows != 16'hFFFF)) begin
        r_perf_rows <= r_perf_rows + 16'd1;
      end
      if ((r_state == S_STREAM) && !in_valid && (r_perf_bubbles != 16'hFFFF)) begin
        r_perf_bubbles <= r_perf_bubbles + 16'd1;
      end
    end
  end

  assign perf_rows    = r_perf_rows;
  assign perf_bubbles = r_perf_bubbles;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder (N=2): stimulus table with a time-keyed lane scoreboard,
// plus a hand-written mid-operation reset sequence.
module tb_systolic_feeder;

  localparam int unsigned N      = 2;
  localparam int unsigned DATA_W = 16;
  localparam int          NVEC   = 17;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [N*DATA_W-1:0] in_row;
  logic                in_last;
  logic [N*DATA_W-1:0] sys_data_out;
  logic [N-1:0]        lane_valid;
  logic                sys_start;
  logic                busy;
  logic                done;
`ifdef SYSTOLIC_FEEDER_PERF_EN
  logic [15:0]         perf_rows;
  logic [15:0]         perf_bubbles;
`endif

  always #5 clk = ~clk;

  systolic_feeder #(.N(N), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_row       (in_row),
    .in_last      (in_last),
    .sys_data_out (sys_data_out),
    .lane_valid   (lane_valid),
    .sys_start    (sys_start),
    .busy         (busy),
    .done         (done)
`ifdef SYSTOLIC_FEEDER_PERF_EN
    ,
    .perf_rows    (perf_rows),
    .perf_bubbles (perf_bubbles)
`endif
  );

  typedef struct {
    logic        v;
    logic        last;
    logic [15:0] e0;
    logic [15:0] e1;
    logic        exp_ready;
    logic        exp_busy;
    logic        bub;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [15:0] data;
  } ev_t;

  vec_t vecs [NVEC];
  ev_t  sb0 [$];
  ev_t  sb1 [$];
  int   done_q [$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_rows = 0;
  int   exp_bubs = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic v, input logic l, input logic [15:0] e0,
                         input logic [15:0] e1, input logic r, input logic b, input logic bb);
    vecs[i] = '{v, l, e0, e1, r, b, bb};
  endtask

  // Compare lanes and done against whatever the scoreboard says is due in cycle k.
  task automatic check_outputs(input int k);
    logic [15:0] x0, x1;
    logic        v0e, v1e, de;
    x0 = '0; x1 = '0; v0e = 1'b0; v1e = 1'b0; de = 1'b0;
    if (sb0.size() > 0) check("sb0_order", 32'(sb0[0].cyc >= k), 32'd1);
    if (sb1.size() > 0) check("sb1_order", 32'(sb1[0].cyc >= k), 32'd1);
    if (sb0.size() > 0 && sb0[0].cyc == k) begin
      x0 = sb0[0].data; v0e = 1'b1; void'(sb0.pop_front());
    end
    if (sb1.size() > 0 && sb1[0].cyc == k) begin
      x1 = sb1[0].data; v1e = 1'b1; void'(sb1.pop_front());
    end
    if (done_q.size() > 0 && done_q[0] == k) begin
      de = 1'b1; void'(done_q.pop_front());
    end
    check($sformatf("lane0_valid@%0d", k), 32'(lane_valid[0]), 32'(v0e));
    check($sformatf("lane0_data@%0d", k), 32'(sys_data_out[15:0]), 32'(x0));
    check($sformatf("lane1_valid@%0d", k), 32'(lane_valid[1]), 32'(v1e));
    check($sformatf("lane1_data@%0d", k), 32'(sys_data_out[31:16]), 32'(x1));
    check($sformatf("sys_start@%0d", k), 32'(sys_start), 32'(v0e));
    check($sformatf("done@%0d", k), 32'(done), 32'(de));
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_lane_valid"}, 32'(lane_valid), 32'd0);
    check({tag, "_data"}, sys_data_out, 32'd0);
    check({tag, "_sys_start"}, 32'(sys_start), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    // bubble matrix, matrix A, held-valid during DRAIN, single-row matrix, idle tail
    set_vec(0,  1, 0, 16'h0A00, 16'h0B00, 1, 0, 0);
    set_vec(1,  0, 0, 16'h0000, 16'h0000, 1, 1, 1);
    set_vec(2,  1, 1, 16'h0C00, 16'h0D00, 1, 1, 0);
    set_vec(3,  0, 0, 16'h0000, 16'h0000, 0, 1, 0);
    set_vec(4,  0, 0, 16'h0000, 16'h0000, 0, 1, 0);
    set_vec(5,  1, 0, 16'h0100, 16'h0200, 1, 0, 0);
    set_vec(6,  1, 1, 16'h0500, 16'h0600, 1, 1, 0);
    set_vec(7,  1, 1, 16'h0700, 16'h0800, 0, 1, 0);
    set_vec(8,  1, 1, 16'h0700, 16'h0800, 0, 1, 0);
    set_vec(9,  1, 1, 16'h0700, 16'h0800, 1, 0, 0);
    set_vec(10, 0, 0, 16'h0000, 16'h0000, 0, 1, 0);
    set_vec(11, 0, 0, 16'h0000, 16'h0000, 0, 1, 0);
    set_vec(12, 1, 1, 16'h0300, 16'hFF00, 1, 0, 0);
    set_vec(13, 0, 0, 16'h0000, 16'h0000, 0, 1, 0);
    set_vec(14, 0, 0, 16'h0000, 16'h0000, 0, 1, 0);
    set_vec(15, 0, 0, 16'h0000, 16'h0000, 1, 0, 0);
    set_vec(16, 0, 0, 16'h0000, 16'h0000, 1, 0, 0);

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_row = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    check("reset_in_ready", 32'(in_ready), 32'd0);
`ifdef SYSTOLIC_FEEDER_PERF_EN
    check("reset_perf_rows", 32'(perf_rows), 32'd0);
    check("reset_perf_bubbles", 32'(perf_bubbles), 32'd0);
`endif
    rst = 1'b0;

    for (int k = 0; k < NVEC; k++) begin
      @(negedge clk);
      check_outputs(k);
      check($sformatf("in_ready@%0d", k), 32'(in_ready), 32'(vecs[k].exp_ready));
      check($sformatf("busy@%0d", k), 32'(busy), 32'(vecs[k].exp_busy));
`ifdef SYSTOLIC_FEEDER_PERF_EN
      check($sformatf("perf_rows@%0d", k), 32'(perf_rows), 32'(exp_rows));
      check($sformatf("perf_bubbles@%0d", k), 32'(perf_bubbles), 32'(exp_bubs));
`endif
      in_valid = vecs[k].v;
      in_last  = vecs[k].last;
      in_row   = {vecs[k].e1, vecs[k].e0};
      if (vecs[k].v && vecs[k].exp_ready) begin
        sb0.push_back('{k + 1, vecs[k].e0});
        sb1.push_back('{k + 2, vecs[k].e1});
        exp_rows++;
        if (vecs[k].last) done_q.push_back(k + 2);
      end
      if (vecs[k].bub) exp_bubs++;
    end
    check("sb_drained", 32'(sb0.size() + sb1.size() + done_q.size()), 32'd0);

    // Abort a matrix while lane 1 still holds its final element.
    @(negedge clk);
    check("abort_ready0", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_last = 1'b0; in_row = {16'h1200, 16'h1100};
    @(negedge clk);
    check("abort_lane0_a", 32'(sys_data_out[15:0]), 32'h1100);
    in_valid = 1'b1; in_last = 1'b1; in_row = {16'h1400, 16'h1300};
    @(negedge clk);
    check("abort_lane0_b", 32'(sys_data_out[15:0]), 32'h1300);
    check("abort_lane1_a", 32'(sys_data_out[31:16]), 32'h1200);
    check("abort_lanes_valid", 32'(lane_valid), 32'd3);
    check("abort_busy", 32'(busy), 32'd1);
    in_valid = 1'b0; in_last = 1'b0; in_row = '0;
    rst = 1'b1;
    #1;
    check("abort_ready_in_rst", 32'(in_ready), 32'd0);
    @(negedge clk);
    check_quiet("after_rst");
    rst = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check_quiet($sformatf("post_rst%0d", j));
      check($sformatf("post_rst%0d_ready", j), 32'(in_ready), 32'd1);
    end
`ifdef SYSTOLIC_FEEDER_PERF_EN
    check("post_rst_perf_rows", 32'(perf_rows), 32'd0);
    check("post_rst_perf_bubbles", 32'(perf_bubbles), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
Upstream stage of the systolic array. Accepts activation rows (one row of N Q8.8 values per beat) over a valid/ready handshake. Emits them diagonally skewed onto the array's left-edge data inputs, so lane i lags lane 0 by i cycles. Generates sys_start and per-lane valids, and signals end-of-matrix so the weight controller can switch weights.

Parameters:
N, 2, number of array rows/lanes (N >= 1)
DATA_W, 16, element width (Q8.8 signed fixed point)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  row beat valid
in_ready  output  1  feeder can accept a row
in_row  input  N*DATA_W  activation row; element i in bits [i*DATA_W +: DATA_W]
in_last  input  1  marks last row of the current matrix
sys_data_out  output  N*DATA_W  lane i drives array row i input (lane 0 = sys_data_in_1x, lane 1 = sys_data_in_2x)
lane_valid  output  N  lane i currently carries a real element
sys_start  output  1  array compute enable; equals lane_valid[0]
busy  output  1  state != IDLE
done  output  1  one-cycle pulse, last element of matrix on lane N-1

Behaviour:
- Reset (sync, rst=1 at an edge): all delay registers, sys_data_out, lane_valid, sys_start, done cleared to 0; state -> IDLE. in_ready is 0 while rst is high.
- Reset mid-operation discards in-flight data. No partial-skew residue after reset.
- FSM states: IDLE, STREAM, DRAIN.
  - IDLE -> STREAM on an accepted beat with in_last=0.
  - IDLE or STREAM -> DRAIN on an accepted beat with in_last=1.
  - STREAM holds otherwise.
  - DRAIN -> IDLE after exactly N cycles.
- in_ready = 1 in IDLE and STREAM, 0 in DRAIN and during reset. No downstream backpressure; array always consumes.
- Accept = in_valid & in_ready.
- Skew: each lane i has an i-stage data+valid delay line behind a common input register.
  - Row accepted in cycle c: element i appears on lane i in cycle c+1+i, with lane_valid[i]=1.
- Bubbles: cycles with no accept insert zero data with valid 0 at lane 0. The bubble propagates diagonally; relative skew between rows is preserved.
- Lanes not carrying a real element drive data 0 (never X/hold).
- sys_start = lane_valid[0], registered, combinationally identical.
- in_last accepted in cycle c:
  - DRAIN occupies cycles c+1..c+N.
  - done=1 in cycle c+N only; it coincides with the last element on lane N-1.
  - First new accept is possible in cycle c+N+1.
- Single-row matrix (in_last on first beat) is legal; it goes IDLE -> DRAIN directly.
- Data passes unmodified; no arithmetic, no width change.
- busy = 1 in STREAM and DRAIN.

Optional Feature:
- Macro SYSTOLIC_FEEDER_PERF_EN.
- When defined, adds outputs:
  - perf_rows (16 bit): count of accepted beats.
  - perf_bubbles (16 bit): cycles in STREAM with in_valid=0.
- Both saturate at 0xFFFF and clear only on rst.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Matrix A rows {0x0100,0x0200}, {0x0500,0x0600}, back-to-back, in_last on row 2, accepts at c0,c1 -> lane0: 0x0100@c0+1, 0x0500@c0+2. lane1: 0x0200@c0+2, 0x0600@c0+3. sys_start high c0+1..c0+2. done only @c0+3. in_ready low c0+2..c0+3.
- Single row {0x0300,0xFF00} with in_last -> lane0 0x0300@+1, lane1 0xFF00@+2, done@+2. in_ready back high @+3.
- Bubble: row1, idle cycle, row2(last) -> lane0 valid pattern 1,0,1. lane1 pattern 1,0,1 shifted one cycle. Idle slots carry data 0.
- in_valid held high in DRAIN with new row 0x0700 -> not accepted until in_ready=1; first emitted on lane0 one cycle after that accept.
- rst asserted while lane1 still holds a pending element -> next cycle all outputs 0, busy 0, done never pulses for the aborted matrix.
- With SYSTOLIC_FEEDER_PERF_EN: scenario 3 -> perf_rows=2, perf_bubbles=1. Without the macro the bench compiles against the base port list.
